// File: rtl/ff_trace_pkg.sv
// Shared definitions for the FF trace capture block.
//   DEF_*           default parameter values for ff_trace_capture
//   trace_entry_t   layout of one captured entry {ts, I, O} at default widths
//   entry_width()   packed entry width for arbitrary TS/DATA widths
package ff_trace_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 1;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_TS_WIDTH   = 16;
    localparam int unsigned DEF_DROP_WIDTH = 8;
    localparam int unsigned ENTRY_WIDTH    = DEF_TS_WIDTH + 2 * DEF_DATA_WIDTH;

    // Field order defines the packing used by the FIFO: ts in the MSBs, O in the LSBs.
    typedef struct packed {
        logic [DEF_TS_WIDTH-1:0]   ts;
        logic [DEF_DATA_WIDTH-1:0] i;
        logic [DEF_DATA_WIDTH-1:0] o;
    } trace_entry_t;

    function automatic int unsigned entry_width(int unsigned ts_w, int unsigned data_w);
        return ts_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   CLK, RESET  clock, synchronous active-high reset (clears pointers and count)
//   push, wdata write request and data; ignored when full unless a pop happens too
//   pop         read request; ignored when empty
//   rdata       head entry, valid whenever empty=0
//   full, empty occupancy flags
//   count       current occupancy, 0..DEPTH
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("trace_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW + 1)'(DEPTH));
        do_pop  = pop & ~empty;
        // When full, a push is only taken if the head leaves in the same cycle.
        do_push = push & (~full | do_pop);
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; contents are only observed while count != 0.
    always_ff @(posedge CLK) begin
        if (do_push && !RESET) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ff_trace_capture.sv
// Captures {timestamp, ff_I, ff_O} of a clock-enabled FF on every enabled cycle into a
// small FIFO that a debug consumer drains over valid/ready. A full FIFO never stalls the
// FF: excess captures are dropped and counted.
//   CLK, RESET      clock, synchronous active-high reset
//   CE, en          capture event when both are high
//   ff_I, ff_O      FF input and (pre-edge) output to record
//   clear           pulse: clears overflow and drop_count, FIFO untouched
//   out_valid/ready head entry handshake; out_ts/out_I/out_O show the head entry
//   count           FIFO occupancy
//   overflow        sticky drop indicator
//   drop_count      saturating count of dropped captures
module ff_trace_capture
    import ff_trace_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned TS_WIDTH   = DEF_TS_WIDTH,
    parameter int unsigned DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CE,
    input  logic [DATA_WIDTH-1:0]    ff_I,
    input  logic [DATA_WIDTH-1:0]    ff_O,
    input  logic                     en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [DATA_WIDTH-1:0]    out_I,
    output logic [DATA_WIDTH-1:0]    out_O,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_WIDTH-1:0]    drop_count
);

    localparam int unsigned EntryW = entry_width(TS_WIDTH, DATA_WIDTH);

    logic [TS_WIDTH-1:0]   ts_q;
    logic                  overflow_q;
    logic [DROP_WIDTH-1:0] drop_count_q;

    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] rd_entry;

    always_comb begin
        push     = CE & en;
        pop      = ~fifo_empty & out_ready;
        // A pop in the same cycle frees the slot, so only push-into-full-without-pop drops.
        drop     = push & fifo_full & ~pop;
        wr_entry = {ts_q, ff_I, ff_O};
    end

    trace_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ts_q         <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            // A drop in the same cycle as clear wins: the new drop is the only one counted.
            if (drop) begin
                overflow_q <= 1'b1;
                if (clear) begin
                    drop_count_q <= DROP_WIDTH'(1);
                end else if (!(&drop_count_q)) begin
                    drop_count_q <= drop_count_q + 1'b1;
                end
            end else if (clear) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    // Head fields read as zero while empty so the outputs are defined straight out of reset.
    always_comb begin
        out_valid  = ~fifo_empty;
        out_ts     = '0;
        out_I      = '0;
        out_O      = '0;
        if (!fifo_empty) begin
            out_ts = rd_entry[EntryW-1 -: TS_WIDTH];
            out_I  = rd_entry[2*DATA_WIDTH-1 -: DATA_WIDTH];
            out_O  = rd_entry[DATA_WIDTH-1:0];
        end
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end

endmodule

// File: tb/tb_ff_trace_capture.sv
module tb_ff_trace_capture;

    localparam int unsigned DW = 1;
    localparam int unsigned DP = 8;
    localparam int unsigned TW = 16;
    localparam int unsigned XW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          CE;
    logic [DW-1:0] ff_I;
    logic [DW-1:0] ff_O;
    logic          en;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_ts;
    logic [DW-1:0] out_I;
    logic [DW-1:0] out_O;
    logic [3:0]    count;
    logic          overflow;
    logic [XW-1:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    ff_trace_capture #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .TS_WIDTH   (TW),
        .DROP_WIDTH (XW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CE         (CE),
        .ff_I       (ff_I),
        .ff_O       (ff_O),
        .en         (en),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ts     (out_ts),
        .out_I      (out_I),
        .out_O      (out_O),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled at the negedge; one call spans one posedge.
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1; CE = 1'b0; en = 1'b1; clear = 1'b0; out_ready = 1'b0;
        ff_I = '0; ff_O = '0;
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_ts !== 16'd0) $display("FAIL reset_ts: got %0d want 0", out_ts);
        else n_pass++;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL idle_valid: got %0b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (count !== 4'd0) $display("FAIL idle_count: got %0d want 0", count);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL idle_overflow: got %0b want 0", overflow);
        else n_pass++;
        n_checks++;
        if (drop_count !== 8'd0) $display("FAIL idle_drop: got %0d want 0", drop_count);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        CE = 1'b1; ff_I = 1'b1; ff_O = 1'b0;
        step();
        CE = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid);
        else n_pass++;
        n_checks++;
        if (out_ts !== 16'd3) $display("FAIL single_ts: got %0d want 3", out_ts);
        else n_pass++;
        n_checks++;
        if (out_I !== 1'b1 || out_O !== 1'b0)
            $display("FAIL single_data: got I=%0b O=%0b want I=1 O=0", out_I, out_O);
        else n_pass++;
        n_checks++;
        if (count !== 4'd1) $display("FAIL single_count: got %0d want 1", count);
        else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 4'd0)
            $display("FAIL single_pop: got valid=%0b count=%0d want 0/0", out_valid, count);
        else n_pass++;
        // en=0 suppresses capture even with CE high
        CE = 1'b1; en = 1'b0;
        step();
        CE = 1'b0; en = 1'b1;
        n_checks++;
        if (count !== 4'd0) $display("FAIL en_off_count: got %0d want 0", count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        CE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ff_I = DW'(i & 1);
            ff_O = DW'((i >> 1) & 1);
            step();
        end
        CE = 1'b0;
        n_checks++;
        if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow);
        else n_pass++;
        n_checks++;
        if (drop_count !== 8'd2) $display("FAIL ovf_drop: got %0d want 2", drop_count);
        else n_pass++;
        step();
        n_checks++;
        if (out_ts !== 16'd0 || out_valid !== 1'b1)
            $display("FAIL ovf_hold: got ts=%0d valid=%0b want 0/1", out_ts, out_valid);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_ts !== 16'(i) || out_I !== DW'(i & 1)
                || out_O !== DW'((i >> 1) & 1))
                $display("FAIL ovf_drain%0d: got v=%0b ts=%0d I=%0b O=%0b want ts=%0d",
                         i, out_valid, out_ts, out_I, out_O, i);
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL ovf_empty: got count=%0d valid=%0b want 0/0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        do_reset();
        CE = 1'b1;
        for (int i = 0; i < 8; i++) step();
        out_ready = 1'b1;
        step();
        CE = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (count !== 4'd8) $display("FAIL fullpop_count: got %0d want 8", count);
        else n_pass++;
        n_checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0)
            $display("FAIL fullpop_drop: got drop=%0d ovf=%0b want 0/0", drop_count, overflow);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_ts !== 16'(i))
                $display("FAIL fullpop_drain%0d: got v=%0b ts=%0d want 1/%0d",
                         i, out_valid, out_ts, i);
            else n_pass++;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturate_clear();
        do_reset();
        CE = 1'b1;
        for (int i = 0; i < 8 + 300; i++) step();
        CE = 1'b0;
        n_checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1)
            $display("FAIL sat_drop: got drop=%0d ovf=%0b want 255/1", drop_count, overflow);
        else n_pass++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0 || count !== 4'd8)
            $display("FAIL clear: got drop=%0d ovf=%0b count=%0d want 0/0/8",
                     drop_count, overflow, count);
        else n_pass++;
        CE = 1'b1; clear = 1'b1;
        step();
        CE = 1'b0; clear = 1'b0;
        n_checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b1)
            $display("FAIL clear_drop: got drop=%0d ovf=%0b want 1/1", drop_count, overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        CE = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (count !== 4'd5) $display("FAIL mid_fill: got %0d want 5", count);
        else n_pass++;
        RESET = 1'b1; ff_I = 1'b1; ff_O = 1'b0;
        step();
        RESET = 1'b0; CE = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL mid_reset: got count=%0d valid=%0b want 0/0", count, out_valid);
        else n_pass++;
        CE = 1'b1; ff_I = 1'b0; ff_O = 1'b1;
        step();
        CE = 1'b0;
        n_checks++;
        if (count !== 4'd1 || out_ts !== 16'd0 || out_I !== 1'b0 || out_O !== 1'b1)
            $display("FAIL mid_after: got count=%0d ts=%0d I=%0b O=%0b want 1/0/0/1",
                     count, out_ts, out_I, out_O);
        else n_pass++;
    endtask

    initial begin
        RESET = 1'b1; CE = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        ff_I = '0; ff_O = '0;
        step();
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_saturate_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ff_trace_capture.md
Name: ff_trace_capture

Overview:
- Hardware counterpart of the simulation-only `$fdisplay` logger attached to the clock-enabled FF stage.
- Sits directly downstream of that FF. On every cycle where CE is high, it captures the FF's input and output plus a cycle timestamp into a small FIFO.
- A consumer (debug UART/JTAG bridge) drains entries over a valid/ready interface.
- Overflow is counted rather than stalling the FF pipeline.

Parameters:
- DATA_WIDTH, 1, width of the captured FF I and O signals
- DEPTH, 8, FIFO entries; power of two, minimum 2
- TS_WIDTH, 16, free-running timestamp width in bits
- DROP_WIDTH, 8, width of the saturating dropped-sample counter

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- CE  in  1  FF clock enable; a capture event occurs when CE=1 and en=1
- ff_I  in  DATA_WIDTH  FF data input (value sampled by the FF this edge)
- ff_O  in  DATA_WIDTH  FF data output (value before this edge's update)
- en  in  1  capture enable; 0 suppresses all captures
- clear  in  1  single-cycle pulse: clears overflow and drop_count (FIFO untouched)
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_ts  out  TS_WIDTH  head entry timestamp
- out_I  out  DATA_WIDTH  head entry ff_I
- out_O  out  DATA_WIDTH  head entry ff_O
- count  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one capture dropped
- drop_count  out  DROP_WIDTH  dropped captures, saturating at all-ones

Behaviour:
- Reset (RESET=1 at posedge, wins over everything):
  - timestamp, FIFO pointers, count, overflow and drop_count go to 0.
  - out_valid=0; out_ts/out_I/out_O=0.
  - A capture or pop in the reset cycle is discarded.
- Timestamp:
  - Increments by 1 every non-reset cycle and wraps modulo 2^TS_WIDTH.
  - A captured entry carries the timestamp value before that edge's increment. The first capture after reset has ts=0 if it occurs in the first cycle.
- Capture:
  - push = CE & en. The entry {ts, ff_I, ff_O} is written at the posedge.
  - It is visible at the outputs from the next cycle (1-cycle latency, first-word-fall-through).
- Pop: pop = out_valid & out_ready. The head advances at the posedge.
- Outputs:
  - out_valid = (count != 0). out_* show the head entry combinationally from FIFO storage.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Full:
  - If push and count==DEPTH and no pop, the entry is dropped.
  - overflow <= 1; drop_count <= drop_count+1, saturating at 2^DROP_WIDTH-1.
- Full with simultaneous pop: the push is accepted, count stays DEPTH, and nothing is dropped.
- Empty with simultaneous push: out_valid stays 0 that cycle. There is no bypass; the entry appears next cycle.
- clear vs drop in the same cycle: the drop wins, giving overflow=1 and drop_count=1.
- Pointers: log2(DEPTH) bits, wrap naturally. count updates +1 / -1 / 0.
- No state machine beyond the FIFO occupancy states (EMPTY / PARTIAL / FULL), all derived from count.

Decomposition:
- Shared package ff_trace_pkg holds:
  - entry typedef {ts, I, O}
  - ENTRY_WIDTH = TS_WIDTH + 2*DATA_WIDTH
  - default parameter constants
- One sub-module, trace_fifo: a generic synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty, count.
- ff_trace_capture contains the timestamp counter, drop/overflow logic and the FIFO instance.

Test Plan:
- Reset then idle 5 cycles (CE=0) -> out_valid=0, count=0, overflow=0, drop_count=0.
- Capture at cycle 3 after reset with CE=1, en=1, ff_I=1, ff_O=0 -> next cycle out_valid=1, out_ts=3, out_I=1, out_O=0, count=1. With out_ready=1 the entry pops and out_valid=0 the following cycle.
- DEPTH=8, out_ready=0, CE=1 for 10 cycles -> count=8, overflow=1, drop_count=2. Draining shows the 8 oldest timestamps in order, consecutive.
- Full FIFO, CE=1 and out_ready=1 in the same cycle -> count stays 8, drop_count unchanged, newest entry present at the tail on drain.
- drop_count preset by 300 drops with DROP_WIDTH=8 -> saturates at 255. A clear pulse with no drop -> 0/0. Clear coinciding with a drop -> overflow=1, drop_count=1.
- RESET asserted with 5 entries queued and CE=1 -> next cycle count=0, out_valid=0, timestamp restarts at 0, and the capture in the reset cycle is absent.
